// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: pops first-word-fall-through words and packs `pack` of them into
// one wide valid/ready beat. A flush emits a partially filled beat with per-lane keep flags.
module fifo_rd_packer #(
  parameter int unsigned datawidth = 8,
  parameter int unsigned pack      = 4
) (
  input  logic                        rclk,
  input  logic                        rrst,
  input  logic                        rempty,
  input  logic [datawidth-1:0]        rdata,
  output logic                        rinc,
  input  logic                        flush,
  output logic                        flush_done,
  output logic [datawidth*pack-1:0]   out_data,
  output logic [pack-1:0]             out_keep,
  output logic                        out_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [15:0]                 pop_count
);

  localparam int unsigned CntW = $clog2(pack + 1);

  typedef logic [pack-1:0][datawidth-1:0] lanes_t;

  lanes_t            acc_q, acc_d;
  lanes_t            out_data_q, out_data_d;
  logic [pack-1:0]   out_keep_q, out_keep_d;
  logic              out_last_q, out_last_d;
  logic              out_valid_q, out_valid_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              flush_pend_q, flush_pend_d;
  logic              flush_done_q, flush_done_d;
  logic [15:0]       pop_count_q, pop_count_d;

  logic              out_free;
  logic [CntW-1:0]   cnt_pop;
  logic [pack-1:0]   part_keep;

  // Pop strobe: only when a word is available, no flush is pending and a lane is free.
  always_comb begin
    out_free = ~out_valid_q | out_ready;
    rinc     = ~rrst & ~rempty & ~flush_pend_q & (cnt_q < CntW'(pack));
  end

  // Next-state: lane write, beat completion, flush drain and handshake bookkeeping.
  always_comb begin
    acc_d        = acc_q;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;
    out_last_d   = out_last_q;
    out_valid_d  = out_valid_q;
    flush_done_d = 1'b0;
    // A flush arriving while one is already pending has no extra effect.
    flush_pend_d = flush_pend_q | flush;
    pop_count_d  = pop_count_q + 16'(rinc);
    cnt_pop      = cnt_q + CntW'(rinc);
    cnt_d        = cnt_pop;

    for (int unsigned i = 0; i < pack; i++) begin
      if (rinc && (cnt_q == CntW'(i))) begin
        acc_d[i] = rdata;
      end
      part_keep[i] = (CntW'(i) < cnt_q);
    end

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (flush_pend_q && out_free) begin
      // No pop can happen here (rinc is held off by flush_pend), so acc_q is complete.
      flush_pend_d = 1'b0;
      flush_done_d = 1'b1;
      if (cnt_q != '0) begin
        for (int unsigned i = 0; i < pack; i++) begin
          out_data_d[i] = part_keep[i] ? acc_q[i] : '0;
        end
        out_keep_d  = part_keep;
        out_last_d  = 1'b1;
        out_valid_d = 1'b1;
        cnt_d       = '0;
      end
    end else if ((cnt_pop == CntW'(pack)) && out_free) begin
      out_data_d  = acc_d;
      out_keep_d  = '1;
      out_last_d  = 1'b0;
      out_valid_d = 1'b1;
      cnt_d       = '0;
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      acc_q        <= '0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      flush_done_q <= 1'b0;
      pop_count_q  <= '0;
    end else begin
      acc_q        <= acc_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
      out_last_q   <= out_last_d;
      out_valid_q  <= out_valid_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      flush_done_q <= flush_done_d;
      pop_count_q  <= pop_count_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_keep   = out_keep_q;
  assign out_last   = out_last_q;
  assign out_valid  = out_valid_q;
  assign flush_done = flush_done_q;
  assign pop_count  = pop_count_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer: a queue-based reference predicts pops and beats,
// a separate monitor pops expected beats whenever the DUT hands one off.
module tb_fifo_rd_packer;

  localparam int DW = 8;
  localparam int PK = 4;

  logic               rclk = 1'b0;
  logic               rrst = 1'b1;
  logic               rempty = 1'b1;
  logic [DW-1:0]      rdata = '0;
  logic               rinc;
  logic               flush = 1'b0;
  logic               flush_done;
  logic [DW*PK-1:0]   out_data;
  logic [PK-1:0]      out_keep;
  logic               out_last;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [15:0]        pop_count;

  fifo_rd_packer #(.datawidth(DW), .pack(PK)) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .rempty    (rempty),
    .rdata     (rdata),
    .rinc      (rinc),
    .flush     (flush),
    .flush_done(flush_done),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pop_count (pop_count)
  );

  always #5 rclk = ~rclk;

  typedef struct packed {
    logic [DW*PK-1:0] data;
    logic [PK-1:0]    keep;
    logic             last;
  } beat_t;

  beat_t         sb[$];
  logic [DW-1:0] fifo[$];
  int            total = 0;
  int            bad = 0;

  // Stimulus controls, written by the sequence at posedge, applied by the driver at negedge.
  bit c_rst = 1'b1, c_flush = 1'b0, c_ready = 1'b0, c_rand_ready = 1'b0, c_rand_stall = 1'b0;

  // Reference state: words collected since the last beat boundary, output slot, pending flush.
  logic [DW-1:0] m_acc[$];
  bit            m_slot = 1'b0, m_pend = 1'b0, m_fdone = 1'b0, m_justrst = 1'b0, armed = 1'b0;
  logic [15:0]   m_pops = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic beat_t mk_beat(input bit last);
    beat_t b;
    b = '0;
    for (int i = 0; i < m_acc.size(); i++) begin
      b.data[i*DW +: DW] = m_acc[i];
      b.keep[i]          = 1'b1;
    end
    b.last = last;
    return b;
  endfunction

  // Driver + reference model: apply inputs for the next edge, then predict that edge.
  always @(negedge rclk) begin
    bit exp_rinc, free, pend_old;
    rrst      = c_rst;
    flush     = c_flush;
    c_flush   = 1'b0;
    out_ready = c_rst ? 1'b0 : (c_rand_ready ? 1'($urandom % 2) : c_ready);
    rempty    = (fifo.size() == 0) || (c_rand_stall && ($urandom % 4 == 0));
    rdata     = rempty ? DW'($urandom) : fifo[0];
    #1;
    exp_rinc = !rrst && !rempty && !m_pend && (m_acc.size() < PK);
    if (armed) begin
      check("rinc", 64'(rinc), 64'(exp_rinc));
      check("out_valid", 64'(out_valid), 64'(m_slot));
      check("flush_done", 64'(flush_done), 64'(m_fdone));
      check("pop_count", 64'(pop_count), 64'(m_pops));
      if (m_justrst) begin
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_keep", 64'(out_keep), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
      end
    end
    if (rinc && fifo.size() > 0) void'(fifo.pop_front());
    if (rrst) begin
      m_acc.delete();
      sb.delete();
      m_slot = 1'b0; m_pend = 1'b0; m_fdone = 1'b0; m_pops = '0;
      m_justrst = 1'b1;
      armed = 1'b1;
    end else begin
      m_justrst = 1'b0;
      free      = !m_slot || out_ready;
      pend_old  = m_pend;
      if (m_slot && out_ready) m_slot = 1'b0;
      if (exp_rinc) begin
        m_acc.push_back(rdata);
        m_pops++;
      end
      m_fdone = 1'b0;
      if (pend_old && free) begin
        if (m_acc.size() > 0) begin
          sb.push_back(mk_beat(1'b1));
          m_slot = 1'b1;
          m_acc.delete();
        end
        m_pend  = 1'b0;
        m_fdone = 1'b1;
      end else if (m_acc.size() == PK && free) begin
        sb.push_back(mk_beat(1'b0));
        m_slot = 1'b1;
        m_acc.delete();
      end
      if (flush && !pend_old) m_pend = 1'b1;
    end
  end

  // Monitor: each beat the DUT hands off is compared against the oldest expected beat.
  always @(negedge rclk) begin
    beat_t e;
    #2;
    if (armed && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", 64'(out_data), 64'd0);
        if (out_data == '0) begin
          bad++;
          $display("FAIL unexpected_beat: got beat with no expected beat queued");
        end
      end else begin
        e = sb.pop_front();
        check("beat_data", 64'(out_data), 64'(e.data));
        check("beat_keep", 64'(out_keep), 64'(e.keep));
        check("beat_last", 64'(out_last), 64'(e.last));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge rclk);
  endtask

  task automatic push_words(input logic [DW-1:0] first, input int n, input logic [DW-1:0] step);
    logic [DW-1:0] w;
    w = first;
    for (int i = 0; i < n; i++) begin
      fifo.push_back(w);
      w = w + step;
    end
  endtask

  task automatic drain(input int maxc);
    int k;
    k = 0;
    while (fifo.size() > 0 && k < maxc) begin
      @(posedge rclk);
      k++;
    end
    check("drain_timeout", 64'(fifo.size()), 64'd0);
  endtask

  task automatic pulse_flush();
    @(posedge rclk);
    c_flush = 1'b1;
  endtask

  initial begin
    int target;
    c_rst = 1'b1; c_ready = 1'b1;
    idle(3);
    c_rst = 1'b0;

    // Basic 4-word beat.
    push_words(8'h11, 4, 8'h11);
    drain(20);
    idle(4);

    // Backpressure: first beat held while the accumulator fills, then two beats in order.
    c_ready = 1'b0;
    push_words(8'h11, 8, 8'h11);
    idle(14);
    c_ready = 1'b1;
    drain(20);
    idle(6);

    // Partial flush of three words, then pops resume at lane 0.
    push_words(8'hA1, 3, 8'h01);
    idle(6);
    pulse_flush();
    idle(1);
    push_words(8'hB1, 4, 8'h01);
    drain(20);
    idle(6);

    // Flush with nothing accumulated, then flush blocked by a held beat.
    pulse_flush();
    idle(4);
    c_ready = 1'b0;
    push_words(8'hC1, 4, 8'h01);
    idle(8);
    pulse_flush();
    idle(5);
    c_ready = 1'b1;
    idle(5);

    // Reset with a held beat and two accumulated words.
    c_ready = 1'b0;
    push_words(8'hD1, 4, 8'h01);
    idle(8);
    push_words(8'hE1, 2, 8'h01);
    idle(5);
    c_rst = 1'b1;
    idle(1);
    c_rst = 1'b0;
    push_words(8'hF1, 4, 8'h01);
    c_ready = 1'b1;
    drain(20);
    idle(6);

    // pop_count wrap.
    target = 65534 - int'(m_pops);
    for (int i = 0; i < target; i++) fifo.push_back(DW'($urandom));
    drain(70000);
    idle(2);
    check("pop_count_65534", 64'(pop_count), 64'd65534);
    push_words(8'h31, 3, 8'h01);
    drain(20);
    idle(2);
    check("pop_count_wrap", 64'(pop_count), 64'd1);

    // Randomized traffic with stalls, backpressure, flushes and occasional resets.
    c_rand_ready = 1'b1;
    c_rand_stall = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge rclk);
      c_rst = ($urandom % 700 == 0);
      if ($urandom % 3 == 0) fifo.push_back(DW'($urandom));
      if ($urandom % 25 == 0) c_flush = 1'b1;
    end
    @(posedge rclk);
    c_rst = 1'b0;
    c_rand_ready = 1'b0;
    c_rand_stall = 1'b0;
    c_ready = 1'b1;
    drain(200);
    idle(3);
    pulse_flush();
    idle(8);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
Read-side consumer for the async FIFO, living entirely in the read clock domain. It pops words from the FIFO read port (rinc/rdata/rempty) and packs PACK consecutive words into one wide beat. Each beat is presented on a valid/ready output stream. A flush request emits a partially filled beat with lane-keep flags so that trailing words are never stranded.

Parameters:
datawidth, 8, width of one FIFO word
pack, 4, FIFO words per output beat (>=2)

Ports:
rclk  input  1  read-domain clock
rrst  input  1  synchronous active-high reset
rempty  input  1  FIFO empty flag
rdata  input  datawidth  FIFO head word; valid whenever rempty=0 (first-word-fall-through)
rinc  output  1  pop strobe to FIFO; combinational
flush  input  1  single-cycle request to emit the partial accumulator
flush_done  output  1  one-cycle pulse when a flush completes
out_data  output  datawidth*pack  packed beat; lane 0 = first popped word, in bits datawidth-1:0
out_keep  output  pack  per-lane valid flags
out_last  output  1  beat was produced by a flush
out_valid  output  1  beat available
out_ready  input  1  downstream accepts the beat
pop_count  output  16  running count of popped words; wraps

Behaviour:
- Single clock rclk. Reset is synchronous, active-high. All state updates occur on the rising edge of rclk.
- Reset values: cnt=0, accumulator=0, out_data=0, out_keep=0, out_last=0, out_valid=0, flush_pend=0, flush_done=0, pop_count=0.
- rinc is forced to 0 while rrst=1.
- Internal state: accumulator of pack lanes, cnt (0..pack) of filled lanes, flush_pend flag.
- out_free = ~out_valid | out_ready.
- Pop rule: rinc = ~rrst & ~rempty & ~flush_pend & (cnt < pack). rdata is sampled only when rinc=1.
- On a pop:
  - rdata is written to lane cnt.
  - pop_count increments (16-bit wrap, 65535 -> 0).
- Beat completion, when the pop fills lane pack-1:
  - If out_free: at the same edge, out_data takes the full accumulator including the new word, out_keep is all ones, out_last=0, out_valid=1, and cnt becomes 0.
  - Otherwise cnt becomes pack and rinc stays low. When out_free later rises, the beat transfers and cnt becomes 0. No pop occurs in that transfer cycle.
- Pop-to-out_valid latency is 0 extra cycles: out_valid rises at the edge that consumes the completing word.
- Sustained throughput with out_ready=1 is one beat per pack cycles.
- Output hold: while out_valid=1 and out_ready=0, out_data, out_keep and out_last remain stable. A beat is consumed when out_valid and out_ready are both 1. out_valid drops at that edge unless a new beat loads at the same edge.
- Flush sequence:
  - flush=1 sampled at edge t sets flush_pend and stops further pops.
  - At the first later edge where flush_pend=1 and out_free=1:
    - If cnt>0: load the beat with lanes 0..cnt-1 from the accumulator and unused lanes zero. out_keep has its low cnt bits set, out_last=1, out_valid=1, and cnt becomes 0.
    - If cnt==pack, the beat is full with keep all ones and out_last=1.
    - If cnt=0: no beat is loaded.
    - In all cases flush_pend clears and flush_done pulses high for exactly one cycle.
- flush asserted while flush_pend=1 is ignored.
- flush at the same edge as a pop: that pop still happens (flush_pend is not yet set), and the popped word is included in the flushed beat.
- FIFO empty: there are no pops, the accumulator holds indefinitely, and no timeout applies.
- Reset mid-operation: partial accumulator contents, a pending beat and a pending flush are all discarded. The first word popped after reset goes to lane 0.

Test Plan:
1. Reset, then FIFO supplies 0x11,0x22,0x33,0x44 with out_ready=1 -> rinc high for 4 consecutive cycles; one beat out_data=0x44332211, out_keep=4'b1111, out_last=0; pop_count=4.
2. out_ready=0, FIFO supplies 0x11..0x88 -> first beat 0x44332211 held stable; accumulator fills with 0x88776655; rinc low after 8 pops. Raising out_ready -> beats 0x44332211 then 0x88776655, in order, back to back.
3. Pop 0xA1,0xA2,0xA3, then pulse flush with the FIFO still non-empty -> beat 0x00A3A2A1, out_keep=4'b0111, out_last=1, one flush_done pulse. Pops resume afterwards starting at lane 0.
4. flush with cnt=0 and out_valid=0 -> no beat; flush_done high for exactly one cycle, at the edge after flush. Flush while out_ready=0 and out_valid=1 -> flush_done is delayed until out_ready=1.
5. cnt=2 with out_valid=1, assert rrst for one cycle -> all outputs 0 the next cycle and rinc=0 during reset. The next 4 words form a fresh beat.
6. Preload pop_count to 65534 (via pops), then pop 3 words -> pop_count reads 1.
